// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle control unit.
//   statetype_t  main FSM state
//   ctrl_t       raw per-state control word, held in registers by the FSM
//   ALU_*, RES_*, SRCB_*, IMM_*, OP_*, FUNCT_*, COND_*  encodings
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH,
    UNKNOWN
  } statetype_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] IMM_8   = 2'b00;
  localparam logic [1:0] IMM_12  = 2'b01;
  localparam logic [1:0] IMM_24  = 2'b10;
  localparam logic [1:0] IMM_H8  = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] FUNCT_AND = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0010;
  localparam logic [3:0] FUNCT_ADD = 4'b0100;
  localparam logic [3:0] FUNCT_CMP = 4'b1010;
  localparam logic [3:0] FUNCT_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       memw;
    logic       regw;
    logic       nowrite;
    logic       branch;
    logic [1:0] resultsrc;
    logic [1:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
  } ctrl_t;

  localparam ctrl_t CTRL_FETCH = '{
    irwrite:    1'b1,
    nextpc:     1'b1,
    adrsrc:     1'b0,
    memw:       1'b0,
    regw:       1'b0,
    nowrite:    1'b0,
    branch:     1'b0,
    resultsrc:  RES_ALURESULT,
    alucontrol: ALU_ADD,
    alusrca:    1'b1,
    alusrcb:    SRCB_FOUR
  };

endpackage

// File: rtl/mc_cond_unit.sv
// mc_cond_unit: NZCV flags register, condition evaluation and the CondEx
// register that holds the verdict for the instruction in flight.
//   clk, reset     clock, asynchronous active-high reset
//   cond_i         Instr[31:28]
//   alu_flags_i    NZCV from the ALU
//   cond_latch_i   capture CondEx (asserted in DECODE)
//   flag_we_i      flag update request (EXEC with S=1)
//   cv_we_i        C and V also written (arithmetic ops)
//   cond_ex_o      registered CondEx
module mc_cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       cond_latch_i,
  input  logic       flag_we_i,
  input  logic       cv_we_i,
  output logic       cond_ex_o
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = f;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    cond_ex_d = cond_ex_q;
    flags_d   = flags_q;
    if (cond_latch_i) cond_ex_d = cond_met(cond_i, flags_q);
    // Flag writes are gated by the verdict of the executing instruction.
    if (flag_we_i && cond_ex_q) begin
      flags_d[3:2] = alu_flags_i[3:2];
      if (cv_we_i) flags_d[1:0] = alu_flags_i[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign cond_ex_o = cond_ex_q;

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control unit (main FSM, instruction decode,
// condition/flag handling via mc_cond_unit).
//   Parameters: ILLEGAL_HALT (1: park in UNKNOWN on undecodable instruction,
//               0: return to FETCH), MEM_WAIT (extra MEMRD/MEMWR cycles, 0..7)
//   Optional build macro: MC_HALFWORD_EN enables LDRH/STRH decode.
//   Inputs : clk, reset (async, active-high), Instr[31:0], ALUFlags[3:0] (NZCV)
//   Outputs: PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc[1:0], ALUControl[1:0],
//            ALUSrcA, ALUSrcB[1:0], ImmSrc[1:0], RegWrite, RegSrc[1:0]
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter bit          ILLEGAL_HALT = 1'b1,
  parameter int unsigned MEM_WAIT     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic [1:0]  RegSrc
);

  localparam logic [2:0]  WAIT_LAST    = 3'(MEM_WAIT);
  localparam statetype_t  ILLEGAL_NEXT = ILLEGAL_HALT ? UNKNOWN : FETCH;

  statetype_t state_q, state_d;
  logic [2:0] wait_q, wait_d;
  ctrl_t      ctrl_q, ctrl_d;

  logic [1:0] op;
  logic [3:0] rd;
  logic       is_hw;
  logic       dp_legal;
  logic       dp_cmp;
  logic [1:0] dp_alu;
  logic       cond_ex;
  logic       flag_we;
  logic       unused_instr;

  assign op           = Instr[27:26];
  assign rd           = Instr[15:12];
  assign unused_instr = ^Instr;

`ifdef MC_HALFWORD_EN
  assign is_hw = (op == OP_DP) && !Instr[25] && Instr[7] && Instr[4];
`else
  assign is_hw = 1'b0;
`endif

  always_comb begin
    dp_legal = 1'b1;
    dp_cmp   = 1'b0;
    dp_alu   = ALU_ADD;
    case (Instr[24:21])
      FUNCT_ADD: dp_alu = ALU_ADD;
      FUNCT_SUB: dp_alu = ALU_SUB;
      FUNCT_AND: dp_alu = ALU_AND;
      FUNCT_ORR: dp_alu = ALU_ORR;
      FUNCT_CMP: begin
        dp_alu = ALU_SUB;
        dp_cmp = 1'b1;
      end
      default:   dp_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_DP: begin
            if (is_hw)          state_d = MEMADR;
            else if (!dp_legal) state_d = ILLEGAL_NEXT;
            else                state_d = Instr[25] ? EXECI : EXECR;
          end
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: state_d = ILLEGAL_NEXT;
        endcase
      end
      MEMADR: state_d = Instr[20] ? MEMRD : MEMWR;
      MEMRD, MEMWR: begin
        if (wait_q != WAIT_LAST) wait_d = wait_q + 3'd1;
        else                     state_d = (state_q == MEMRD) ? MEMWB : FETCH;
      end
      EXECR, EXECI:          state_d = ALUWB;
      MEMWB, ALUWB, BRANCH:  state_d = FETCH;
      UNKNOWN:               state_d = UNKNOWN;
      default:               state_d = FETCH;
    endcase
  end

  // Control word is decoded from the next state and registered, so each
  // state's outputs appear glitch-free for the whole cycle it is current.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      FETCH:  ctrl_d = CTRL_FETCH;
      DECODE: begin
        ctrl_d.alusrca   = 1'b1;
        ctrl_d.alusrcb   = SRCB_FOUR;
        ctrl_d.resultsrc = RES_ALURESULT;
      end
      EXECR: begin
        ctrl_d.alusrcb    = SRCB_RD2;
        ctrl_d.alucontrol = dp_alu;
      end
      EXECI: begin
        ctrl_d.alusrcb    = SRCB_EXTIMM;
        ctrl_d.alucontrol = dp_alu;
      end
      MEMADR: begin
        ctrl_d.alusrcb    = (is_hw && !Instr[22]) ? SRCB_RD2 : SRCB_EXTIMM;
        ctrl_d.alucontrol = Instr[23] ? ALU_ADD : ALU_SUB;
      end
      MEMRD: ctrl_d.adrsrc = 1'b1;
      MEMWR: begin
        ctrl_d.adrsrc = 1'b1;
        ctrl_d.memw   = 1'b1;
      end
      MEMWB: begin
        ctrl_d.regw      = 1'b1;
        ctrl_d.resultsrc = RES_DATA;
      end
      ALUWB: begin
        ctrl_d.regw      = 1'b1;
        ctrl_d.nowrite   = dp_cmp;
        ctrl_d.resultsrc = RES_ALUOUT;
      end
      BRANCH: begin
        ctrl_d.alusrcb    = SRCB_EXTIMM;
        ctrl_d.alucontrol = ALU_ADD;
        ctrl_d.resultsrc  = RES_ALURESULT;
        ctrl_d.branch     = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
      ctrl_q  <= CTRL_FETCH;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign flag_we = ((state_q == EXECR) || (state_q == EXECI)) && Instr[20];

  mc_cond_unit u_cond (
    .clk          (clk),
    .reset        (reset),
    .cond_i       (Instr[31:28]),
    .alu_flags_i  (ALUFlags),
    .cond_latch_i (state_q == DECODE),
    .flag_we_i    (flag_we),
    .cv_we_i      (~ctrl_q.alucontrol[1]),
    .cond_ex_o    (cond_ex)
  );

  always_comb begin
    case (op)
      OP_DP:   ImmSrc = (is_hw && Instr[22]) ? IMM_H8 : IMM_8;
      OP_MEM:  ImmSrc = IMM_12;
      OP_BR:   ImmSrc = IMM_24;
      default: ImmSrc = IMM_8;
    endcase
  end

  assign RegSrc[0] = (op == OP_BR);
  assign RegSrc[1] = ((op == OP_MEM) || is_hw) && !Instr[20];

  // Reset holds the FETCH selects but masks every write enable, including
  // the FETCH ones, for as long as reset is asserted.
  assign PCWrite  = ~reset & (ctrl_q.nextpc | (ctrl_q.branch & cond_ex) |
                              (ctrl_q.regw & cond_ex & (rd == 4'hF)));
  assign RegWrite = ~reset & ctrl_q.regw & cond_ex & ~ctrl_q.nowrite;
  assign MemWrite = ~reset & ctrl_q.memw & cond_ex;
  assign IRWrite  = ~reset & ctrl_q.irwrite;

  assign AdrSrc     = ctrl_q.adrsrc;
  assign ResultSrc  = ctrl_q.resultsrc;
  assign ALUControl = ctrl_q.alucontrol;
  assign ALUSrcA    = ctrl_q.alusrca;
  assign ALUSrcB    = ctrl_q.alusrcb;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm (MEM_WAIT=2, ILLEGAL_HALT=1).
// Output vector layout: {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
// ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc}.
// Table rows: {Instr[31:0], ALUFlags[3:0], expected[15:0]}, one per cycle.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
  logic [15:0] outs;

  int vectors     = 0;
  int miscompares = 0;

  mc_control_fsm #(.ILLEGAL_HALT(1'b1), .MEM_WAIT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .RegSrc     (RegSrc)
  );

  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                 ALUSrcA, ALUSrcB, ImmSrc, RegWrite, RegSrc};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; Instr = '0; ALUFlags = 4'h9;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (outs !== 16'h08C0) begin
      $display("FAIL reset outs=%h expected %h", outs, 16'h08C0); miscompares++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    logic [51:0] rows [4];
    rows = '{{32'hE2821005, 4'h9, 16'h98C0}, {32'hE2821005, 4'h9, 16'h08C0},
             {32'hE2821005, 4'h9, 16'h0020}, {32'hE2821005, 4'h9, 16'h0004}};
    for (int i = 0; i < 4; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL add[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      @(negedge clk);
    end
  endtask

  // ADD above had S=0 with N=1 on ALUFlags: BMI must not be taken.
  task automatic test_no_s_flags();
    logic [51:0] rows [3];
    rows = '{{32'h4A000000, 4'h9, 16'h98D1}, {32'h4A000000, 4'h9, 16'h08D1},
             {32'h4A000000, 4'h9, 16'h0831}};
    for (int i = 0; i < 3; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL bmi_nos[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pc_write();
    logic [51:0] rows [4];
    rows = '{{32'hE282F005, 4'h9, 16'h98C0}, {32'hE282F005, 4'h9, 16'h08C0},
             {32'hE282F005, 4'h9, 16'h0020}, {32'hE282F005, 4'h9, 16'h8004}};
    for (int i = 0; i < 4; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL add_pc[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ldr_wait();
    logic [51:0] rows [7];
    rows = '{{32'hE5910008, 4'h9, 16'h98C8}, {32'hE5910008, 4'h9, 16'h08C8},
             {32'hE5910008, 4'h9, 16'h0028}, {32'hE5910008, 4'h9, 16'h4008},
             {32'hE5910008, 4'h9, 16'h4008}, {32'hE5910008, 4'h9, 16'h4008},
             {32'hE5910008, 4'h9, 16'h040C}};
    for (int i = 0; i < 7; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL ldr[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      @(negedge clk);
    end
  endtask

  // SUBS R3,R3,R3 (Z=1,C=1), BEQ taken, BNE not taken.
  task automatic test_subs_branch();
    logic [51:0] rows [10];
    rows = '{{32'hE0533003, 4'h9, 16'h98C0}, {32'hE0533003, 4'h9, 16'h08C0},
             {32'hE0533003, 4'h6, 16'h0100}, {32'hE0533003, 4'h9, 16'h0004},
             {32'h0A000004, 4'h9, 16'h98D1}, {32'h0A000004, 4'h9, 16'h08D1},
             {32'h0A000004, 4'h9, 16'h8831},
             {32'h1A000004, 4'h9, 16'h98D1}, {32'h1A000004, 4'h9, 16'h08D1},
             {32'h1A000004, 4'h9, 16'h0831}};
    for (int i = 0; i < 10; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL subs_br[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      @(negedge clk);
    end
  endtask

  // ANDS with C=0 on ALUFlags must keep C=1: BCS taken.
  task automatic test_ands_carry();
    logic [51:0] rows [7];
    rows = '{{32'hE0100000, 4'h9, 16'h98C0}, {32'hE0100000, 4'h9, 16'h08C0},
             {32'hE0100000, 4'h4, 16'h0200}, {32'hE0100000, 4'h9, 16'h0004},
             {32'h2A000000, 4'h9, 16'h98D1}, {32'h2A000000, 4'h9, 16'h08D1},
             {32'h2A000000, 4'h9, 16'h8831}};
    for (int i = 0; i < 7; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL ands_bcs[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_str_cond_fail();
    logic [51:0] rows [6];
    rows = '{{32'h15810004, 4'h9, 16'h98CA}, {32'h15810004, 4'h9, 16'h08CA},
             {32'h15810004, 4'h9, 16'h002A}, {32'h15810004, 4'h9, 16'h400A},
             {32'h15810004, 4'h9, 16'h400A}, {32'h15810004, 4'h9, 16'h400A}};
    for (int i = 0; i < 6; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL str_ne[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_in_memwr();
    logic [51:0] rows [6];
    rows = '{{32'hE5810004, 4'h9, 16'h98CA}, {32'hE5810004, 4'h9, 16'h08CA},
             {32'hE5810004, 4'h9, 16'h002A}, {32'hE5810004, 4'h9, 16'h600A},
             {32'hE5810004, 4'h9, 16'h600A}, {32'hE5810004, 4'h9, 16'h600A}};
    for (int i = 0; i < 4; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL str_pre[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      if (i < 3) @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (MemWrite !== 1'b0) begin
      $display("FAIL reset_memwrite MemWrite=%b expected 0", MemWrite); miscompares++;
    end
    vectors++;
    if (outs !== 16'h08CA) begin
      $display("FAIL reset_mid outs=%h expected %h", outs, 16'h08CA); miscompares++;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL str_post[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      @(negedge clk);
    end
  endtask

  // After reset Z=0: BEQ not taken; CMP sets Z without writing a register; BEQ taken.
  task automatic test_cmp_branch();
    logic [51:0] rows [10];
    rows = '{{32'h0A000004, 4'h9, 16'h98D1}, {32'h0A000004, 4'h9, 16'h08D1},
             {32'h0A000004, 4'h9, 16'h0831},
             {32'hE1510001, 4'h9, 16'h98C0}, {32'hE1510001, 4'h9, 16'h08C0},
             {32'hE1510001, 4'h6, 16'h0100}, {32'hE1510001, 4'h9, 16'h0000},
             {32'h0A000004, 4'h9, 16'h98D1}, {32'h0A000004, 4'h9, 16'h08D1},
             {32'h0A000004, 4'h9, 16'h8831}};
    for (int i = 0; i < 10; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL cmp_br[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      @(negedge clk);
    end
  endtask

`ifdef MC_HALFWORD_EN
  task automatic test_halfword();
    logic [51:0] rows [7];
    rows = '{{32'hE1D102BA, 4'h9, 16'h98D8}, {32'hE1D102BA, 4'h9, 16'h08D8},
             {32'hE1D102BA, 4'h9, 16'h0038}, {32'hE1D102BA, 4'h9, 16'h4018},
             {32'hE1D102BA, 4'h9, 16'h4018}, {32'hE1D102BA, 4'h9, 16'h4018},
             {32'hE1D102BA, 4'h9, 16'h041C}};
    for (int i = 0; i < 7; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL ldrh[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      @(negedge clk);
    end
  endtask
`else
  // Halfword-shaped encoding without the feature is a plain register ADD.
  task automatic test_dp_encoding();
    logic [51:0] rows [4];
    rows = '{{32'hE0812090, 4'h9, 16'h98C0}, {32'hE0812090, 4'h9, 16'h08C0},
             {32'hE0812090, 4'h9, 16'h0000}, {32'hE0812090, 4'h9, 16'h0004}};
    for (int i = 0; i < 4; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL dp_hw_enc[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_illegal();
    logic [51:0] rows [5];
    rows = '{{32'hEC000000, 4'h9, 16'h98C0}, {32'hEC000000, 4'h9, 16'h08C0},
             {32'hEC000000, 4'h9, 16'h0000}, {32'hEC000000, 4'h9, 16'h0000},
             {32'hEC000000, 4'h9, 16'h0000}};
    for (int i = 0; i < 5; i++) begin
      Instr = rows[i][51:20]; ALUFlags = rows[i][19:16]; #1;
      vectors++;
      if (outs !== rows[i][15:0]) begin
        $display("FAIL illegal[%0d] outs=%h expected %h", i, outs, rows[i][15:0]); miscompares++;
      end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (outs !== 16'h08C0) begin
      $display("FAIL illegal_reset outs=%h expected %h", outs, 16'h08C0); miscompares++;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (outs !== 16'h98C0) begin
      $display("FAIL illegal_recover outs=%h expected %h", outs, 16'h98C0); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_no_s_flags();
    test_pc_write();
    test_ldr_wait();
    test_subs_branch();
    test_ands_carry();
    test_str_cond_fail();
    test_reset_in_memwr();
    test_cmp_branch();
`ifdef MC_HALFWORD_EN
    test_halfword();
`else
    test_dp_encoding();
`endif
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
